// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: load/store sequencer for a level-sensitive 256x16 RAM.
// Each request runs setup, strobe and hold phases, then a one-cycle response pulse.
`default_nettype none

module ram_access_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [15:0] resp_rdata,
    output logic [15:0] txn_count,
    output logic        ram_read,
    output logic        ram_write,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_ou
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // A zero wait setting still gives one strobe cycle.
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES <= 1) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

    state_t      state;
    state_t      next_state;
    logic        we_lat;
    logic [3:0]  wait_cnt;
    logic [15:0] rdata_lat;
    logic [15:0] txn_cnt;
    logic        addr_err;
    logic        accept;

    assign addr_err = ({1'b0, req_addr} >= DEPTH_LIM);
    assign accept   = (state == IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = addr_err ? ERR : SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) next_state = HOLD;
            HOLD:    next_state = RESP;
            RESP:    next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address and data are only captured for in-range requests so that an
    // error response leaves the RAM-side buses untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_lat    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_in    <= 16'h0000;
            wait_cnt  <= 4'd0;
            rdata_lat <= 16'h0000;
            txn_cnt   <= 16'h0000;
        end else begin
            if (accept && !addr_err) begin
                we_lat   <= req_we;
                ram_addr <= req_addr;
                ram_in   <= req_wdata;
            end
            if (state == SETUP) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACCESS && wait_cnt == 4'd0 && !we_lat) begin
                rdata_lat <= ram_ou;
            end
            if (state == HOLD) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

    assign req_ready  = rst_n && (state == IDLE);
    assign ram_read   = (state == ACCESS) && !we_lat;
    assign ram_write  = (state == ACCESS) && we_lat;
    assign resp_valid = (state == RESP) || (state == ERR);
    assign resp_err   = (state == ERR);
    assign resp_rdata = (state == ERR) ? 16'h0000 : rdata_lat;
    assign txn_count  = txn_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed checks of ram_access_ctrl with WAIT_CYCLES=1 and 3.
`default_nettype none

module tb_ram_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Instance with WAIT_CYCLES=1, backed by a small memory model.
    logic        v1, rdy1, we1, rv1, re1, rr1, rw1;
    logic [15:0] a1, wd1, rd1, tc1, ra1, ri1, ro1;
    logic [15:0] mem1 [0:255];

    ram_access_ctrl #(.DEPTH(256), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_we(we1), .req_addr(a1), .req_wdata(wd1),
        .resp_valid(rv1), .resp_err(re1), .resp_rdata(rd1), .txn_count(tc1),
        .ram_read(rr1), .ram_write(rw1), .ram_addr(ra1), .ram_in(ri1), .ram_ou(ro1)
    );

    always @(posedge clk) if (rw1) mem1[ra1[7:0]] <= ri1;
    assign ro1 = mem1[ra1[7:0]];

    // Instance with WAIT_CYCLES=3; its RAM returns address ^ 0x5A5A.
    logic        v3, rdy3, we3, rv3, re3, rr3, rw3;
    logic [15:0] a3, wd3, rd3, tc3, ra3, ri3, ro3;

    ram_access_ctrl #(.DEPTH(256), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
        .req_we(we3), .req_addr(a3), .req_wdata(wd3),
        .resp_valid(rv3), .resp_err(re3), .resp_rdata(rd3), .txn_count(tc3),
        .ram_read(rr3), .ram_write(rw3), .ram_addr(ra3), .ram_in(ri3), .ram_ou(ro3)
    );

    assign ro3 = ra3 ^ 16'h5A5A;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic req1(input logic v, input logic we, input logic [15:0] a, input logic [15:0] d);
        v1 = v; we1 = we; a1 = a; wd1 = d;
    endtask

    initial begin
        int n_acc;
        req1(1'b0, 1'b0, 16'h0, 16'h0);
        v3 = 1'b0; we3 = 1'b0; a3 = 16'h0; wd3 = 16'h0;

        // Reset state
        cyc(); cyc();
        check("rst_ready", {15'd0, rdy1}, 16'd0);
        check("rst_valid", {14'd0, rv1, re1}, 16'd0);
        check("rst_strobes", {14'd0, rr1, rw1}, 16'd0);
        check("rst_addr", ra1, 16'h0);
        check("rst_in", ri1, 16'h0);
        check("rst_rdata", rd1, 16'h0);
        check("rst_count", tc1, 16'h0);
        rst_n = 1'b1;
        cyc();
        check("ready_after_rst", {15'd0, rdy1}, 16'd1);

        // Store 0x0012 <- 0xBEEF (cycle 0 = handshake)
        req1(1'b1, 1'b1, 16'h0012, 16'hBEEF);
        check("st_c0_ready", {15'd0, rdy1}, 16'd1);
        cyc(); req1(1'b0, 1'b0, 16'h0, 16'h0);
        check("st_c1_strobes", {14'd0, rr1, rw1}, 16'd0);
        check("st_c1_addr", ra1, 16'h0012);
        check("st_c1_ready", {15'd0, rdy1}, 16'd0);
        cyc();
        check("st_c2_strobes", {14'd0, rr1, rw1}, 16'b01);
        check("st_c2_in", ri1, 16'hBEEF);
        cyc();
        check("st_c3_strobes", {14'd0, rr1, rw1}, 16'd0);
        cyc();
        check("st_c4_resp", {14'd0, rv1, re1}, 16'b10);
        check("st_c4_count", tc1, 16'd1);
        cyc();
        check("st_c5_resp", {14'd0, rv1, re1}, 16'b00);
        check("st_c5_ready", {15'd0, rdy1}, 16'd1);

        // Load 0x0012
        req1(1'b1, 1'b0, 16'h0012, 16'h0);
        cyc(); req1(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        check("ld_c2_strobes", {14'd0, rr1, rw1}, 16'b10);
        cyc(); cyc();
        check("ld_c4_resp", {14'd0, rv1, re1}, 16'b10);
        check("ld_c4_rdata", rd1, 16'hBEEF);
        check("ld_c4_count", tc1, 16'd2);
        cyc();

        // Out-of-range load 0x0100
        req1(1'b1, 1'b0, 16'h0100, 16'h0);
        cyc(); req1(1'b0, 1'b0, 16'h0, 16'h0);
        check("err_c1_resp", {14'd0, rv1, re1}, 16'b11);
        check("err_c1_rdata", rd1, 16'h0);
        check("err_c1_strobes", {14'd0, rr1, rw1}, 16'd0);
        check("err_c1_addr", ra1, 16'h0012);
        check("err_c1_count", tc1, 16'd2);
        cyc();
        check("err_c2_ready", {15'd0, rdy1}, 16'd1);
        check("err_c2_resp", {15'd0, rv1}, 16'd0);

        // WAIT_CYCLES=3 boundary load 0x00FF: read high in cycles 2..4, response in 6
        v3 = 1'b1; we3 = 1'b0; a3 = 16'h00FF;
        check("w3_c0_ready", {15'd0, rdy3}, 16'd1);
        for (int c = 1; c <= 6; c++) begin
            cyc();
            v3 = 1'b0; a3 = 16'h0;
            check($sformatf("w3_c%0d_read", c), {15'd0, rr3}, (c >= 2 && c <= 4) ? 16'd1 : 16'd0);
            check($sformatf("w3_c%0d_write", c), {15'd0, rw3}, 16'd0);
            if (c <= 5) check($sformatf("w3_c%0d_addr", c), ra3, 16'h00FF);
            check($sformatf("w3_c%0d_valid", c), {15'd0, rv3}, (c == 6) ? 16'd1 : 16'd0);
        end
        check("w3_rdata", rd3, 16'h5AA5);
        check("w3_count", tc3, 16'd1);
        cyc();

        // Back-to-back stores with req_valid held high: accepts at cycles 0, 5, 10
        n_acc = 0;
        for (int c = 0; c <= 14; c++) begin
            if (n_acc < 3) req1(1'b1, 1'b1, 16'h0020 + 16'(n_acc), 16'h1111 * 16'(n_acc + 1));
            else           req1(1'b0, 1'b0, 16'h0, 16'h0);
            check($sformatf("b2b_c%0d_overlap", c), {15'd0, rr1 & rw1}, 16'd0);
            if (rdy1 && n_acc < 3) begin
                check($sformatf("b2b_accept%0d_cycle", n_acc), 16'(c), 16'(5 * n_acc));
                n_acc++;
            end
            cyc();
        end
        req1(1'b0, 1'b0, 16'h0, 16'h0);
        check("b2b_n_accepted", 16'(n_acc), 16'd3);
        check("b2b_mem21", mem1[8'h21], 16'h2222);
        check("b2b_mem22", mem1[8'h22], 16'h3333);
        check("b2b_count", tc1, 16'd5);

        // Reset asserted in cycle 2 of a store to 0x0005
        req1(1'b1, 1'b1, 16'h0005, 16'hAAAA);
        cyc(); req1(1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        check("rmid_c2_write", {15'd0, rw1}, 16'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_strobes", {14'd0, rr1, rw1}, 16'd0);
        check("rmid_ready", {15'd0, rdy1}, 16'd0);
        check("rmid_count", tc1, 16'd0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            check("rmid_hold_valid", {15'd0, rv1}, 16'd0);
            check("rmid_hold_ready", {15'd0, rdy1}, 16'd0);
        end
        rst_n = 1'b1;
        cyc();
        check("rmid_release_ready", {15'd0, rdy1}, 16'd1);
        check("rmid_release_valid", {15'd0, rv1}, 16'd0);
        check("rmid_release_count", tc1, 16'd0);

        // txn_count wrap: preload 0xFFFF, next completed access gives 0x0000
        force u1.txn_cnt = 16'hFFFF;
        #1;
        release u1.txn_cnt;
        #1;
        check("wrap_preload", tc1, 16'hFFFF);
        cyc();
        req1(1'b1, 1'b0, 16'h0012, 16'h0);
        cyc(); req1(1'b0, 1'b0, 16'h0, 16'h0);
        cyc(); cyc(); cyc();
        check("wrap_resp", {14'd0, rv1, re1}, 16'b10);
        check("wrap_rdata", rd1, 16'hBEEF);
        check("wrap_count", tc1, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

- Initiator-side sequencer for the 256x16 level-sensitive data RAM.
- Accepts single-word load/store requests from the CPU datapath over a valid/ready handshake and drives the RAM's read, write, address and data ports with a safe setup/strobe/hold sequence.
- Returns read data or write completion as a one-cycle response pulse, and flags out-of-range addresses without touching the RAM.

## Interface
- DEPTH, 256: number of RAM words; addresses >= DEPTH are errors.
- WAIT_CYCLES, 1: cycles the RAM strobe is held; legal range 1-15 (0 behaves as 1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address.
- req_wdata  in  16  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: address out of range.
- resp_rdata  out  16  load data.
- txn_count  out  16  completed RAM accesses, wrapping.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  16  RAM address.
- ram_in  out  16  RAM write data.
- ram_ou  in  16  RAM read data.

## Operation
- The FSM has six states: IDLE, SETUP, ACCESS, HOLD, RESP, ERR. Reset state is IDLE.
- **IDLE**
  - req_ready = 1.
  - A handshake occurs when req_valid && req_ready are high at a rising edge. That edge latches req_we, req_addr and req_wdata.
  - req_addr >= DEPTH → ERR; otherwise → SETUP.
- **SETUP** (1 cycle)
  - ram_addr and ram_in are driven from the latched values.
  - Both strobes are low.
  - → ACCESS; the wait counter loads WAIT_CYCLES-1.
- **ACCESS** (WAIT_CYCLES cycles)
  - Exactly one of ram_read or ram_write is high, per the latched we.
  - The counter decrements each cycle.
  - Loads: ram_ou is captured into the rdata register at the edge ending the last ACCESS cycle.
  - When the counter is 0 → HOLD.
- **HOLD** (1 cycle)
  - Strobes low; ram_addr and ram_in are unchanged.
  - txn_count increments at the edge leaving HOLD.
  - → RESP.
- **RESP** (1 cycle)
  - resp_valid = 1 and resp_err = 0.
  - On a load, resp_rdata shows the captured data. On a store, resp_rdata keeps its previous value.
  - → IDLE.
- **ERR** (1 cycle)
  - resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - No strobe is raised, ram_addr/ram_in are unchanged, and txn_count is unchanged.
  - → IDLE.
- Invariants:
  - ram_read && ram_write is never 1.
  - ram_addr and ram_in never change while either strobe is high.
  - In IDLE, ram_addr and ram_in hold their last values.
- Widths and arithmetic:
  - Address comparison is 16-bit unsigned.
  - txn_count wraps from 0xFFFF to 0x0000.
  - The wait counter is 4 bits.
- There is no response backpressure: the consumer must take resp_valid in the cycle it is high.

## Timing
- Reset values while rst_n = 0:
  - state = IDLE.
  - req_ready = 0; this output is gated with rst_n.
  - resp_valid, resp_err, ram_read, ram_write = 0.
  - resp_rdata, ram_addr, ram_in, txn_count = 0.
- Valid access latency, with the handshake cycle numbered 0:
  - SETUP: cycle 1.
  - ACCESS: cycles 2 .. WAIT_CYCLES+1.
  - HOLD: cycle WAIT_CYCLES+2.
  - RESP: cycle WAIT_CYCLES+3.
  - IDLE (next request may be accepted): cycle WAIT_CYCLES+4.
- Error latency: ERR in cycle 1, IDLE in cycle 2.
- req_ready is 0 in every state except IDLE; req_valid during busy states is ignored and not queued.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to ram_*.
- Reset mid-operation:
  - Strobes drop asynchronously and the FSM returns to IDLE.
  - No response is issued for the in-flight request; txn_count is cleared.
  - A store interrupted during ACCESS may have partially updated the RAM, and software must reissue it.
- Holding req_valid high in IDLE across back-to-back requests gives one accepted request per WAIT_CYCLES+4 cycles.

## Test plan
- Store then load, WAIT_CYCLES=1:
  - Store addr 0x0012 data 0xBEEF → resp_valid in cycle 4 with resp_err=0.
  - Load 0x0012 → resp_rdata=0xBEEF in cycle 4; txn_count=2.
- Out-of-range load addr 0x0100 → resp_valid and resp_err in cycle 1, resp_rdata=0, no ram_read/ram_write pulse, txn_count unchanged.
- WAIT_CYCLES=3:
  - Load addr 0x00FF (boundary) → ram_read high in exactly cycles 2-4, response in cycle 6.
  - Check ram_addr is stable from cycle 1 through cycle 5.
- Back-to-back: req_valid held high with 3 queued stores → ready pulses only in IDLE, requests accepted at cycles 0, 5, 10 (WAIT_CYCLES=1), strobes never overlap.
- Assert rst_n low in cycle 2 of a store to 0x0005 → strobes 0 immediately, no resp_valid, req_ready=0 until release, then 1 in IDLE; txn_count=0.
- Wrap: preload txn_count to 0xFFFF via 65535 loads (or force) → next completed access gives txn_count=0x0000.
